// File: rtl/decode_stage_pkg.sv
// ----------------------------------------------------------------------------
// decode_stage_pkg
// RV32I decode definitions used by the decode stage.
// Contents:
//   opcode_t                  major opcode encodings (LUI .. SYSTEM)
//   rd_t/rs1_t/rs2_t          register index fields
//   funct3_t/funct7_t         function fields
//   inst_fmt_t                immediate format class
//   get_*_f                   field extraction helpers
//   is_legal_opcode_f         recognised major opcodes
//   inst_fmt_f / imm32_f      format selection and 32-bit immediate build
// ----------------------------------------------------------------------------
package decode_stage_pkg;

    localparam int INST_W = 32;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_t;

    typedef logic [4:0] rd_t;
    typedef logic [4:0] rs1_t;
    typedef logic [4:0] rs2_t;
    typedef logic [2:0] funct3_t;
    typedef logic [6:0] funct7_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } inst_fmt_t;

    function automatic logic [6:0] get_opcode_f(input logic [INST_W-1:0] inst);
        return inst[6:0];
    endfunction

    function automatic rd_t get_rd_f(input logic [INST_W-1:0] inst);
        return inst[11:7];
    endfunction

    function automatic funct3_t get_funct3_f(input logic [INST_W-1:0] inst);
        return inst[14:12];
    endfunction

    function automatic rs1_t get_rs1_f(input logic [INST_W-1:0] inst);
        return inst[19:15];
    endfunction

    function automatic rs2_t get_rs2_f(input logic [INST_W-1:0] inst);
        return inst[24:20];
    endfunction

    function automatic funct7_t get_funct7_f(input logic [INST_W-1:0] inst);
        return inst[31:25];
    endfunction

    function automatic logic is_legal_opcode_f(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
            default:                                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // MISC_MEM and SYSTEM carry I-type bit layouts, but this stage reports
    // no immediate for them, so they share the no-immediate class.
    function automatic inst_fmt_t inst_fmt_f(input logic [6:0] opc);
        inst_fmt_t fmt;
        case (opc)
            OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
            OPC_OP_IMM, OPC_JALR, OPC_LOAD:  fmt = FMT_I;
            OPC_STORE:                       fmt = FMT_S;
            OPC_BRANCH:                      fmt = FMT_B;
            OPC_JAL:                         fmt = FMT_J;
            OPC_OP:                          fmt = FMT_R;
            default:                         fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // Every format's sign bit is inst[31], so the 32-bit result can be
    // widened later by a plain signed extension.
    function automatic logic [31:0] imm32_f(input logic [INST_W-1:0] inst,
                                            input inst_fmt_t        fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_lane.sv
// ----------------------------------------------------------------------------
// decode_lane
// Combinational decode of one 32-bit instruction.
// Ports:
//   inst_i     instruction
//   opcode_o   inst[6:0]
//   rd_o       inst[11:7]
//   funct3_o   inst[14:12]
//   rs1_o      inst[19:15]
//   rs2_o      inst[24:20]
//   funct7_o   inst[31:25]
//   immed_o    format-selected immediate, sign-extended to XLEN
//   illegal_o  unrecognised encoding (immed_o forced to 0)
// ----------------------------------------------------------------------------
module decode_lane
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_W-1:0] inst_i,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [XLEN-1:0]   immed_o,
    output logic              illegal_o
);

    inst_fmt_t   fmt;
    logic [31:0] imm32;

    always_comb begin
        opcode_o  = get_opcode_f(inst_i);
        rd_o      = get_rd_f(inst_i);
        funct3_o  = get_funct3_f(inst_i);
        rs1_o     = get_rs1_f(inst_i);
        rs2_o     = get_rs2_f(inst_i);
        funct7_o  = get_funct7_f(inst_i);
        illegal_o = (inst_i[1:0] != 2'b11) || !is_legal_opcode_f(inst_i[6:0]);
        fmt       = inst_fmt_f(inst_i[6:0]);
        imm32     = illegal_o ? 32'd0 : imm32_f(inst_i, fmt);
        immed_o   = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Registered RISC-V decode stage between the fetch buffer and issue.
// Decodes LANES instructions per beat and carries the beat PC.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   drop every held beat
//   in_valid_i / in_ready_o   upstream handshake; inst_i (lane 0 in [31:0]), pc_i
//   out_valid_o / out_ready_i downstream handshake
//   pc_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, immed_o,
//   illegal_o                 registered decode results, lane-packed
// Build option:
//   DECODE_STAGE_SKID_EN      adds a one-entry skid buffer so in_ready_o comes
//                             from a flop instead of from out_ready_i.
// ----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int LANES      = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*32-1:0]     inst_i,
    input  logic [ADDR_WIDTH-1:0]   pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic [LANES*7-1:0]      opcode_o,
    output logic [LANES*5-1:0]      rd_o,
    output logic [LANES*3-1:0]      funct3_o,
    output logic [LANES*5-1:0]      rs1_o,
    output logic [LANES*5-1:0]      rs2_o,
    output logic [LANES*7-1:0]      funct7_o,
    output logic [LANES*XLEN-1:0]   immed_o,
    output logic [LANES-1:0]        illegal_o
);

    localparam int LANE_W = 7 + 5 + 3 + 5 + 5 + 7 + XLEN + 1;
    localparam int BEAT_W = ADDR_WIDTH + LANES * LANE_W;

    logic [LANES*7-1:0]    dec_opcode;
    logic [LANES*5-1:0]    dec_rd;
    logic [LANES*3-1:0]    dec_funct3;
    logic [LANES*5-1:0]    dec_rs1;
    logic [LANES*5-1:0]    dec_rs2;
    logic [LANES*7-1:0]    dec_funct7;
    logic [LANES*XLEN-1:0] dec_immed;
    logic [LANES-1:0]      dec_illegal;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        decode_lane #(.XLEN(XLEN)) u_decode_lane (
            .inst_i    (inst_i[l*INST_W +: INST_W]),
            .opcode_o  (dec_opcode[l*7 +: 7]),
            .rd_o      (dec_rd[l*5 +: 5]),
            .funct3_o  (dec_funct3[l*3 +: 3]),
            .rs1_o     (dec_rs1[l*5 +: 5]),
            .rs2_o     (dec_rs2[l*5 +: 5]),
            .funct7_o  (dec_funct7[l*7 +: 7]),
            .immed_o   (dec_immed[l*XLEN +: XLEN]),
            .illegal_o (dec_illegal[l])
        );
    end

    // The whole beat moves as one vector so the output and skid registers
    // stay a single load each.
    logic [BEAT_W-1:0] dec_beat;
    logic [BEAT_W-1:0] out_q;
    logic [BEAT_W-1:0] out_n;
    logic              out_valid_q;
    logic              out_valid_n;
    logic              accept;

    assign dec_beat = {pc_i, dec_opcode, dec_rd, dec_funct3, dec_rs1, dec_rs2,
                       dec_funct7, dec_immed, dec_illegal};

    assign {pc_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, immed_o,
            illegal_o} = out_q;

    assign out_valid_o = out_valid_q;
    assign accept      = in_valid_i && in_ready_o;

`ifdef DECODE_STAGE_SKID_EN

    logic              skid_valid_q;
    logic              skid_valid_n;
    logic [BEAT_W-1:0] skid_q;
    logic [BEAT_W-1:0] skid_n;
    logic              ready_q;
    logic              out_free;

    // ready_q always mirrors !skid_valid_q; rst_i masks it so the port
    // reads 0 throughout reset and 1 straight after release.
    assign in_ready_o = ready_q && !rst_i;
    assign out_free   = !out_valid_q || out_ready_i;

    // An accept can only happen with the skid empty, so the skid never has
    // to be refilled in the same cycle it drains.
    always_comb begin
        out_valid_n  = out_valid_q;
        out_n        = out_q;
        skid_valid_n = skid_valid_q;
        skid_n       = skid_q;
        if (flush_i) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_n  = 1'b1;
                out_n        = skid_q;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                out_valid_n = 1'b1;
                out_n       = dec_beat;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_n       = dec_beat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_n;
            out_q        <= out_n;
            skid_valid_q <= skid_valid_n;
            skid_q       <= skid_n;
            ready_q      <= !skid_valid_n;
        end
    end

`else

    assign in_ready_o = (!out_valid_q || out_ready_i) && !rst_i;

    // The held beat is only replaced on accept; a stalled output blocks
    // accept through in_ready_o, which keeps the outputs stable.
    always_comb begin
        out_valid_n = out_valid_q;
        out_n       = out_q;
        if (flush_i) begin
            out_valid_n = 1'b0;
        end else if (accept) begin
            out_valid_n = 1'b1;
            out_n       = dec_beat;
        end else if (out_ready_i) begin
            out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_n;
            out_q       <= out_n;
        end
    end

`endif

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage with LANES=2, XLEN=64, ADDR_WIDTH=32.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN  = 64;
    localparam int LANES = 2;
    localparam int AW    = 32;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*32-1:0]   inst;
    logic [AW-1:0]         pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [AW-1:0]         pc_q;
    logic [LANES*7-1:0]    opcode;
    logic [LANES*5-1:0]    rd;
    logic [LANES*3-1:0]    funct3;
    logic [LANES*5-1:0]    rs1;
    logic [LANES*5-1:0]    rs2;
    logic [LANES*7-1:0]    funct7;
    logic [LANES*XLEN-1:0] immed;
    logic [LANES-1:0]      illegal;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.XLEN(XLEN), .LANES(LANES), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inst_i      (inst),
        .pc_i        (pc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pc_o        (pc_q),
        .opcode_o    (opcode),
        .rd_o        (rd),
        .funct3_o    (funct3),
        .rs1_o       (rs1),
        .rs2_o       (rs2),
        .funct7_o    (funct7),
        .immed_o     (immed),
        .illegal_o   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Drives one beat for one edge; caller ensures in_ready is high.
    task automatic send(input logic [63:0] insts, input logic [31:0] pcv);
        in_valid = 1'b1;
        inst     = insts;
        pc       = pcv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        inst = 64'h00000013_FFF10093; pc = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (pc_q !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_q); end
        n_checks++; if (opcode !== 14'h0 || immed !== 128'h0 || illegal !== 2'b00)
            begin n_fail++; $display("FAIL reset_fields got=%h/%h/%b exp=0", opcode, immed, illegal); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_addi_lui;
        out_ready = 1'b1;
        send({32'h123452B7, 32'hFFF10093}, 32'h0000_1000);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        n_checks++; if (opcode[6:0] !== 7'h13) begin n_fail++; $display("FAIL addi_opcode got=%h exp=13", opcode[6:0]); end
        n_checks++; if (rd[4:0] !== 5'd1) begin n_fail++; $display("FAIL addi_rd got=%0d exp=1", rd[4:0]); end
        n_checks++; if (rs1[4:0] !== 5'd2) begin n_fail++; $display("FAIL addi_rs1 got=%0d exp=2", rs1[4:0]); end
        n_checks++; if (funct3[2:0] !== 3'd0) begin n_fail++; $display("FAIL addi_funct3 got=%0d exp=0", funct3[2:0]); end
        n_checks++; if (immed[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL addi_immed got=%h exp=ffffffffffffffff", immed[63:0]); end
        n_checks++; if (illegal !== 2'b00) begin n_fail++; $display("FAIL addi_illegal got=%b exp=00", illegal); end
        n_checks++; if (immed[127:64] !== 64'h0000_0000_1234_5000) begin n_fail++; $display("FAIL lui_immed got=%h exp=12345000", immed[127:64]); end
        n_checks++; if (rd[9:5] !== 5'd5) begin n_fail++; $display("FAIL lui_rd got=%0d exp=5", rd[9:5]); end
        n_checks++; if (opcode[13:7] !== 7'h37) begin n_fail++; $display("FAIL lui_opcode got=%h exp=37", opcode[13:7]); end
        n_checks++; if (pc_q !== 32'h0000_1000) begin n_fail++; $display("FAIL addi_pc got=%h exp=1000", pc_q); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_jal_sw;
        out_ready = 1'b1;
        send({32'h00512423, 32'hFFDFF06F}, 32'h0000_2000);
        n_checks++; if (opcode[6:0] !== 7'h6F) begin n_fail++; $display("FAIL jal_opcode got=%h exp=6f", opcode[6:0]); end
        n_checks++; if (immed[63:0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL jal_immed got=%h exp=fffffffffffffffc", immed[63:0]); end
        n_checks++; if (rd[4:0] !== 5'd0) begin n_fail++; $display("FAIL jal_rd got=%0d exp=0", rd[4:0]); end
        n_checks++; if (immed[127:64] !== 64'd8) begin n_fail++; $display("FAIL sw_immed got=%h exp=8", immed[127:64]); end
        n_checks++; if (rs2[9:5] !== 5'd5) begin n_fail++; $display("FAIL sw_rs2 got=%0d exp=5", rs2[9:5]); end
        n_checks++; if (rs1[9:5] !== 5'd2) begin n_fail++; $display("FAIL sw_rs1 got=%0d exp=2", rs1[9:5]); end
        n_checks++; if (funct3[5:3] !== 3'd2) begin n_fail++; $display("FAIL sw_funct3 got=%0d exp=2", funct3[5:3]); end
        n_checks++; if (illegal !== 2'b00) begin n_fail++; $display("FAIL jal_sw_illegal got=%b exp=00", illegal); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_branch_op;
        out_ready = 1'b1;
        // lw x1,-8(x2) in lane 0, beq x0,x0,-4 in lane 1
        send({32'hFE000EE3, 32'hFF812083}, 32'h0000_2100);
        n_checks++; if (immed[63:0] !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL lw_immed got=%h exp=fffffffffffffff8", immed[63:0]); end
        n_checks++; if (funct3[2:0] !== 3'd2 || rs1[4:0] !== 5'd2 || rd[4:0] !== 5'd1)
            begin n_fail++; $display("FAIL lw_fields got=f3 %0d rs1 %0d rd %0d exp=2 2 1", funct3[2:0], rs1[4:0], rd[4:0]); end
        n_checks++; if (immed[127:64] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL beq_immed got=%h exp=fffffffffffffffc", immed[127:64]); end
        @(posedge clk); #1;
        // ecall in lane 0, add x3,x1,x2 in lane 1
        send({32'h002081B3, 32'h00000073}, 32'h0000_2200);
        n_checks++; if (immed !== 128'h0) begin n_fail++; $display("FAIL sys_op_immed got=%h exp=0", immed); end
        n_checks++; if (illegal !== 2'b00) begin n_fail++; $display("FAIL sys_op_illegal got=%b exp=00", illegal); end
        n_checks++; if (rs2[9:5] !== 5'd2 || rs1[9:5] !== 5'd1 || rd[9:5] !== 5'd3)
            begin n_fail++; $display("FAIL add_fields got=rs2 %0d rs1 %0d rd %0d exp=2 1 3", rs2[9:5], rs1[9:5], rd[9:5]); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        send({32'h0000007F, 32'h00000000}, 32'h0000_2300);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_kept got=%b exp=1", out_valid); end
        n_checks++; if (illegal !== 2'b11) begin n_fail++; $display("FAIL illegal_flags got=%b exp=11", illegal); end
        n_checks++; if (immed !== 128'h0) begin n_fail++; $display("FAIL illegal_immed got=%h exp=0", immed); end
        n_checks++; if (opcode[13:7] !== 7'h7F) begin n_fail++; $display("FAIL illegal_opcode got=%h exp=7f", opcode[13:7]); end
        @(posedge clk); #1;
        // addi with inst[1:0]=01 in lane 1: fields kept, immediate suppressed
        send({32'hFFF10091, 32'hFFF10093}, 32'h0000_2400);
        n_checks++; if (illegal !== 2'b10) begin n_fail++; $display("FAIL lowbits_flags got=%b exp=10", illegal); end
        n_checks++; if (immed[127:64] !== 64'h0) begin n_fail++; $display("FAIL lowbits_immed got=%h exp=0", immed[127:64]); end
        n_checks++; if (rd[9:5] !== 5'd1) begin n_fail++; $display("FAIL lowbits_rd got=%0d exp=1", rd[9:5]); end
        n_checks++; if (immed[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL lowbits_lane0 got=%h exp=ffffffffffffffff", immed[63:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        held_valid = 1'b0;
        logic [31:0] held_pc = '0;
        logic [31:0] lane0;
        while (got < 4 && cyc < 40) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (sent < 4);
            lane0     = 32'((sent + 1) << 20) | 32'h0000_0013;
            inst      = {32'h0000_0013, lane0};
            pc        = 32'h0000_3000 + 32'(4 * sent);
            #1;
            if (held_valid) begin
                n_checks++; if (out_valid !== 1'b1 || pc_q !== held_pc)
                    begin n_fail++; $display("FAIL stall_hold got=%b/%h exp=1/%h", out_valid, pc_q, held_pc); end
            end
            if (out_valid && out_ready) begin
                n_checks++; if (pc_q !== 32'h0000_3000 + 32'(4 * got))
                    begin n_fail++; $display("FAIL stream_order got=%h exp=%h", pc_q, 32'h0000_3000 + 32'(4 * got)); end
                n_checks++; if (immed[63:0] !== 64'(got + 1))
                    begin n_fail++; $display("FAIL stream_immed got=%h exp=%0d", immed[63:0], got + 1); end
                got++;
            end
            held_valid = out_valid && !out_ready;
            held_pc    = pc_q;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL stream_count got=%0d exp=4 (cycle budget)", got); end
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dup got=%b exp=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        flush = 1'b1; in_valid = 1'b1;
        inst = {32'h0000_0013, 32'hFFF10093}; pc = 32'h0000_4000;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept got=%b exp=0", out_valid); end
        send({32'h0000_0013, 32'h123452B7}, 32'h0000_4004);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || pc_q !== 32'h0000_4004)
            begin n_fail++; $display("FAIL post_flush_beat got=%b/%h exp=1/4004", out_valid, pc_q); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || immed[63:0] !== 64'h1234_5000)
            begin n_fail++; $display("FAIL flush_hold got=%b/%h exp=1/12345000", out_valid, immed[63:0]); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_held got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send({32'h123452B7, 32'hFFF10093}, 32'h0000_5000);
        rst = 1'b1; in_valid = 1'b1; pc = 32'h0000_5004;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || pc_q !== 32'h0) begin n_fail++; $display("FAIL midrst_valid_pc got=%b/%h exp=0/0", out_valid, pc_q); end
        n_checks++; if (opcode !== 14'h0 || rd !== 10'h0 || rs1 !== 10'h0 || rs2 !== 10'h0 || funct3 !== 6'h0 || funct7 !== 14'h0)
            begin n_fail++; $display("FAIL midrst_fields got=%h %h %h %h exp=0", opcode, rd, rs1, funct7); end
        n_checks++; if (immed !== 128'h0 || illegal !== 2'b00) begin n_fail++; $display("FAIL midrst_immed got=%h/%b exp=0", immed, illegal); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dropped got=%b exp=0", out_valid); end
    endtask

`ifdef DECODE_STAGE_SKID_EN
    task automatic test_skid;
        logic r0;
        out_ready = 1'b0;
        send({32'h0000_0013, 32'h0010_0013}, 32'h0000_6000);
        r0 = in_ready;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== r0) begin n_fail++; $display("FAIL skid_ready_comb got=%b exp=%b", in_ready, r0); end
        out_ready = 1'b0;
        send({32'h0000_0013, 32'h0020_0013}, 32'h0000_6004);
        n_checks++; if (in_ready !== 1'b0 || pc_q !== 32'h0000_6000)
            begin n_fail++; $display("FAIL skid_full got=%b/%h exp=0/6000", in_ready, pc_q); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || pc_q !== 32'h0000_6004)
            begin n_fail++; $display("FAIL skid_drain got=%b/%h exp=1/6004", out_valid, pc_q); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; pc = '0;
        test_reset();
        test_addi_lui();
        test_jal_sw();
        test_load_branch_op();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef DECODE_STAGE_SKID_EN
        test_skid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
